// File: rtl/freq_gen.sv
// Programmable square-wave generator: freq_in (Hz) -> half-period count via a 32-cycle restoring divider.
// Optional burst mode is compiled in with FREQ_GEN_BURST_EN.
module freq_gen #(
    parameter int unsigned CLOCK_FREQ = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] freq_in,
    input  logic        load,
    input  logic        enable,
    output logic        ready,
    output logic        signal_out,
    output logic [31:0] half_period,
    output logic        cfg_done,
`ifdef FREQ_GEN_BURST_EN
    input  logic [15:0] burst_len,
    output logic        burst_done,
`endif
    output logic        cfg_err
);

    localparam logic [31:0] DIVIDEND = 32'(CLOCK_FREQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVIDE,
        S_PENDING
    } state_t;

    state_t      state_q, state_d;
    logic        ready_q, ready_d;
    logic        sig_q, sig_d;
    logic [31:0] hp_q, hp_d;
    logic        cfg_done_q, cfg_done_d;
    logic        cfg_err_q, cfg_err_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] tick_q, tick_d;
    logic [4:0]  div_cnt_q, div_cnt_d;
    logic [31:0] dvd_q, dvd_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [32:0] dvs_q, dvs_d;

    logic [33:0] rem_sh;
    logic [32:0] rem_sub;
    logic        q_bit;
    logic [31:0] quo_next;
    logic        hold_now;
    logic        run;
    logic        toggle;

    // Remainder stays below the 33-bit divisor, so the low 33 bits of the difference are exact.
    assign rem_sh   = {rem_q, dvd_q[31]};
    assign q_bit    = rem_sh >= {1'b0, dvs_q};
    assign rem_sub  = rem_sh[32:0] - dvs_q;
    assign quo_next = {quo_q[30:0], q_bit};

`ifdef FREQ_GEN_BURST_EN
    logic        en_prev_q, en_prev_d;
    logic [15:0] left_q, left_d;
    logic        active_q, active_d;
    logic        hold_q, hold_d;
    logic        bdone_q, bdone_d;
    logic        en_rise;
    logic [15:0] left_b;
    logic        active_b;

    assign hold_now   = hold_q;
    assign en_rise    = enable && !en_prev_q;
    assign left_b     = en_rise ? burst_len : left_q;
    assign active_b   = en_rise ? (burst_len != 16'd0) : active_q;
    assign burst_done = bdone_q;
`else
    assign hold_now = 1'b0;
`endif

    assign run    = enable && (hp_q != 32'd0) && !hold_now;
    assign toggle = run && (tick_q == hp_q - 32'd1);

    always_comb begin
        state_d    = state_q;
        ready_d    = ready_q;
        sig_d      = sig_q;
        hp_d       = hp_q;
        cfg_done_d = 1'b0;
        cfg_err_d  = cfg_err_q;
        pend_d     = pend_q;
        tick_d     = tick_q;
        div_cnt_d  = div_cnt_q;
        dvd_d      = dvd_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;

        if (!run) begin
            tick_d = 32'd0;
            sig_d  = 1'b0;
        end else if (toggle) begin
            tick_d = 32'd0;
            sig_d  = !sig_q;
        end else begin
            tick_d = tick_q + 32'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (load && ready_q) begin
                    ready_d   = 1'b0;
                    cfg_err_d = 1'b0;
                    if (freq_in == 32'd0) begin
                        pend_d    = 32'd0;
                        cfg_err_d = 1'b1;
                        state_d   = S_PENDING;
                    end else begin
                        dvs_d     = {freq_in, 1'b0};
                        dvd_d     = DIVIDEND;
                        rem_d     = 33'd0;
                        quo_d     = 32'd0;
                        div_cnt_d = 5'd31;
                        state_d   = S_DIVIDE;
                    end
                end
            end
            S_DIVIDE: begin
                dvd_d = {dvd_q[30:0], 1'b0};
                rem_d = q_bit ? rem_sub : rem_sh[32:0];
                quo_d = quo_next;
                if (div_cnt_q == 5'd0) begin
                    state_d = S_PENDING;
                    if (quo_next == 32'd0) begin
                        pend_d    = 32'd1;
                        cfg_err_d = 1'b1;
                    end else begin
                        pend_d = quo_next;
                    end
                end else begin
                    div_cnt_d = div_cnt_q - 5'd1;
                end
            end
            S_PENDING: begin
                // Swap only on a toggle edge of a live waveform so no phase is truncated.
                if (!run || toggle) begin
                    hp_d       = pend_q;
                    tick_d     = 32'd0;
                    cfg_done_d = 1'b1;
                    ready_d    = 1'b1;
                    state_d    = S_IDLE;
                    if (pend_q == 32'd0) begin
                        sig_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

`ifdef FREQ_GEN_BURST_EN
    always_comb begin
        en_prev_d = enable;
        left_d    = left_b;
        active_d  = active_b;
        hold_d    = hold_q;
        bdone_d   = 1'b0;
        if (!enable) begin
            active_d = 1'b0;
            hold_d   = 1'b0;
        end else if (toggle && active_b) begin
            if (!sig_q) begin
                left_d = left_b - 16'd1;
            end else if (left_b == 16'd0) begin
                hold_d   = 1'b1;
                active_d = 1'b0;
                bdone_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_prev_q <= 1'b0;
            left_q    <= 16'd0;
            active_q  <= 1'b0;
            hold_q    <= 1'b0;
            bdone_q   <= 1'b0;
        end else begin
            en_prev_q <= en_prev_d;
            left_q    <= left_d;
            active_q  <= active_d;
            hold_q    <= hold_d;
            bdone_q   <= bdone_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ready_q    <= 1'b1;
            sig_q      <= 1'b0;
            hp_q       <= 32'd0;
            cfg_done_q <= 1'b0;
            cfg_err_q  <= 1'b0;
            pend_q     <= 32'd0;
            tick_q     <= 32'd0;
            div_cnt_q  <= 5'd0;
            dvd_q      <= 32'd0;
            rem_q      <= 33'd0;
            quo_q      <= 32'd0;
            dvs_q      <= 33'd0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            sig_q      <= sig_d;
            hp_q       <= hp_d;
            cfg_done_q <= cfg_done_d;
            cfg_err_q  <= cfg_err_d;
            pend_q     <= pend_d;
            tick_q     <= tick_d;
            div_cnt_q  <= div_cnt_d;
            dvd_q      <= dvd_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
        end
    end

    assign ready       = ready_q;
    assign signal_out  = sig_q;
    assign half_period = hp_q;
    assign cfg_done    = cfg_done_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_freq_gen.sv
// Scoreboard bench for freq_gen: config results and phase lengths are queued as expectations
// and checked by monitors when the DUT presents cfg_done or a signal_out transition.
module tb_freq_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] freq_in;
    logic        load;
    logic        enable;
    logic        ready;
    logic        signal_out;
    logic [31:0] half_period;
    logic        cfg_done;
    logic        cfg_err;
`ifdef FREQ_GEN_BURST_EN
    logic [15:0] burst_len;
    logic        burst_done;
`endif

    freq_gen #(.CLOCK_FREQ(50000000)) dut (
        .clk        (clk),
        .rst        (rst),
        .freq_in    (freq_in),
        .load       (load),
        .enable     (enable),
        .ready      (ready),
        .signal_out (signal_out),
        .half_period(half_period),
        .cfg_done   (cfg_done),
`ifdef FREQ_GEN_BURST_EN
        .burst_len  (burst_len),
        .burst_done (burst_done),
`endif
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hp;
        logic        err;
        int          lat;
    } cfg_t;

    cfg_t cfg_q[$];
    int   ph_q[$];
    cfg_t exp_c;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   load_cyc = 0;
    int   min_ph = 1000000;
    int   ph_cnt = 0;
    logic prev_sig = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_ge(input string name, input longint act, input longint lim);
        n_cmp++;
        if (act < lim) begin
            n_bad++;
            $display("FAIL %s: got %0d expected >= %0d", name, act, lim);
        end
    endtask

    // cfg_done monitor
    always @(negedge clk) begin
        if (!rst && cfg_done) begin
            if (cfg_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_cfg_done: got hp %0d expected no event (cycle %0d)", half_period, cyc);
            end else begin
                exp_c = cfg_q.pop_front();
                cmp("cfg_half_period", half_period, exp_c.hp);
                cmp("cfg_err", cfg_err, exp_c.err);
                if (exp_c.lat >= 0) cmp("cfg_latency", cyc - load_cyc, exp_c.lat);
            end
        end
    end

    // phase-length monitor
    always @(negedge clk) begin
        if (rst) begin
            ph_cnt   = 0;
            prev_sig = 1'b0;
        end else if (signal_out != prev_sig) begin
            if (ph_cnt < min_ph) min_ph = ph_cnt;
            if (ph_q.size() > 0) cmp("phase_len", ph_cnt, ph_q.pop_front());
            ph_cnt   = 1;
            prev_sig = signal_out;
        end else begin
            ph_cnt++;
        end
    end

    task automatic do_load(input logic [31:0] f, input bit push, input logic [31:0] hp,
                           input bit err, input int lat);
        cfg_t e;
        @(negedge clk);
        freq_in = f;
        load    = 1'b1;
        if (push) begin
            e.hp  = hp;
            e.err = err;
            e.lat = lat;
            cfg_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (push) load_cyc = cyc;
        load = 1'b0;
    endtask

    task automatic wait_rise(input int max);
        logic last;
        bit   ok;
        last = signal_out;
        ok   = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (signal_out && !last) begin
                ok = 1'b1;
                break;
            end
            last = signal_out;
        end
        #1;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_rise_timeout: got no rising edge expected one within %0d cycles", max);
        end
    endtask

    task automatic push_phases(input int len, input int n);
        for (int i = 0; i < n; i++) ph_q.push_back(len);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cnt;
        int  c0;
        bit  hi_seen;
`ifdef FREQ_GEN_BURST_EN
        int  rises;
        int  dones;
        logic last;
`endif
        rst     = 1'b1;
        load    = 1'b0;
        enable  = 1'b0;
        freq_in = 32'd0;
`ifdef FREQ_GEN_BURST_EN
        burst_len = 16'd0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cmp("rst_signal_out", signal_out, 0);
        cmp("rst_half_period", half_period, 0);
        cmp("rst_ready", ready, 1);
        cmp("rst_cfg_err", cfg_err, 0);
        cmp("rst_cfg_done", cfg_done, 0);

        // 1 MHz from idle output
        enable = 1'b1;
        do_load(32'd1000000, 1, 32'd25, 0, 33);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ready) break;
            cnt++;
        end
        cmp("ready_low_cycles", cnt, 33);
        c0 = cyc;
        wait_rise(200);
        cmp("first_rise_delay", cyc - c0, 25);
        push_phases(25, 4);
        repeat (110) @(negedge clk);

        // reset mid-run
        rst = 1'b1;
        @(posedge clk);
        #1;
        cmp("midrun_rst_signal_out", signal_out, 0);
        cmp("midrun_rst_half_period", half_period, 0);
        cmp("midrun_rst_ready", ready, 1);
        cmp("midrun_rst_cfg_err", cfg_err, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        cmp("idle_after_rst_signal_out", signal_out, 0);
        cmp("idle_after_rst_half_period", half_period, 0);

        // freq_in == 0
        do_load(32'd0, 1, 32'd0, 1, 1);
        hi_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (signal_out) hi_seen = 1'b1;
        end
        cmp("zero_freq_output_low", hi_seen, 0);

        // above CLOCK_FREQ/2 -> clamps to 1
        do_load(32'd30000000, 1, 32'd1, 1, 33);
        repeat (36) @(negedge clk);
        wait_rise(20);
        push_phases(1, 4);
        repeat (8) @(negedge clk);

        // back to 1 MHz while running
        do_load(32'd1000000, 1, 32'd25, 0, -1);
        repeat (40) @(negedge clk);
        wait_rise(100);
        push_phases(25, 4);
        repeat (105) @(negedge clk);

        // retune 1 MHz -> 500 kHz while running, second load during DIVIDE ignored
        wait_rise(100);
        min_ph = 1000000;
        do_load(32'd500000, 1, 32'd50, 0, -1);
        repeat (10) @(negedge clk);
        cmp("ready_during_divide", ready, 0);
        do_load(32'd2500000, 0, 32'd0, 0, -1);
        repeat (80) @(negedge clk);
        wait_rise(200);
        cmp("retune_half_period", half_period, 50);
        push_phases(50, 4);
        repeat (210) @(negedge clk);
        check_ge("retune_min_phase", min_ph, 25);

        // reset during DIVIDE cycle 10
        enable = 1'b0;
        do_load(32'd1000000, 0, 32'd0, 0, -1);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        cmp("div_rst_ready", ready, 1);
        cmp("div_rst_half_period", half_period, 0);
        cmp("div_rst_cfg_done", cfg_done, 0);
        cmp("div_rst_cfg_err", cfg_err, 0);
        cmp("div_rst_signal_out", signal_out, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        do_load(32'd2500000, 1, 32'd10, 0, 33);
        repeat (40) @(negedge clk);
        enable = 1'b1;
        wait_rise(100);
        push_phases(10, 4);
        repeat (50) @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        #1;
        cmp("disable_signal_out", signal_out, 0);

`ifdef FREQ_GEN_BURST_EN
        do_load(32'd1000000, 1, 32'd25, 0, 33);
        repeat (40) @(negedge clk);
        burst_len = 16'd3;
        enable    = 1'b1;
        rises = 0;
        dones = 0;
        last  = signal_out;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (signal_out && !last) rises++;
            if (burst_done) dones++;
            last = signal_out;
        end
        cmp("burst_rises", rises, 3);
        cmp("burst_done_pulses", dones, 1);
        cmp("burst_end_low", signal_out, 0);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        wait_rise(100);
        enable = 1'b0;
        dones  = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (burst_done) dones++;
        end
        cmp("burst_abort_done", dones, 0);
        cmp("burst_abort_low", signal_out, 0);
`endif

        repeat (5) @(negedge clk);
        cmp("cfg_queue_left", cfg_q.size(), 0);
        cmp("phase_queue_left", ph_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/freq_gen.md
Name: freq_gen

Overview:
- Programmable square-wave generator that produces `signal_out` at a requested frequency in Hz.
- It is the stimulus-side counterpart of the team's input-capture frequency counter; it drives test tones and reference clocks.
- It converts `freq_in` into a half-period count with a multi-cycle sequential divider, with no combinational divide.
- It applies new settings glitch-free at a toggle boundary.

Parameters:
- CLOCK_FREQ, 50000000, system clock frequency in Hz; also the divider dividend. Must fit in 32 bits.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- freq_in  input  32  requested output frequency, Hz; sampled on an accepted load
- load  input  1  configuration strobe; accepted only when ready=1
- enable  input  1  1 = waveform runs; 0 = output forced low
- ready  output  1  1 when a new load can be accepted
- signal_out  output  1  generated square wave
- half_period  output  32  active half-period in clk cycles; 0 = no valid config
- cfg_done  output  1  one-cycle pulse when a new config becomes active
- cfg_err  output  1  set by a load with an out-of-range freq_in; held until the next accepted load

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset values: ready=1, signal_out=0, half_period=0, cfg_done=0, cfg_err=0, pending=0, tick counter=0, state=IDLE.
- States:
  - IDLE: ready=1. Accepted load (load=1 and ready=1 at an edge) captures freq_in, clears cfg_err, sets ready=0.
    - freq_in==0 → PENDING with q=0 and cfg_err=1.
    - otherwise → DIVIDE.
  - DIVIDE: restoring divider, exactly 32 cycles, q = floor(CLOCK_FREQ / (2*freq_in)). The divisor is held 33 bits wide. Then → PENDING.
    - If q==0, i.e. freq_in > CLOCK_FREQ/2: q=1 and cfg_err=1.
  - PENDING: the new q is swapped into half_period, then → IDLE with ready=1.
    - Swap timing: the cycle the running waveform next toggles, or immediately if enable=0 or half_period==0.
    - cfg_done pulses in the swap cycle.
    - On swap, the tick counter resets to 0.
- Load while ready=0 is ignored. No queueing.
- Waveform:
  - With enable=1 and half_period≠0, the tick counter counts 0..half_period-1.
  - At half_period-1 it wraps to 0 and signal_out toggles.
  - Output frequency is CLOCK_FREQ/(2*half_period).
  - The first rising edge occurs half_period cycles after enable rises, or after the swap.
- enable=0: signal_out=0 and counter=0 from the next edge. Configuration is retained.
- half_period==0: signal_out held low, including after a freq_in==0 load.
- Latency from an idle output: cfg_done is high exactly 33 cycles after the load edge. For freq_in==0 it is 1 cycle.
- Running output: the old waveform continues unchanged through DIVIDE. No high or low phase is ever shorter than min(old, new) half_period.
- Reset mid-DIVIDE or mid-PENDING: abandons the operation and restores all reset values.
- Arithmetic: all counters are 32-bit unsigned. The divider truncates and does not round.

Optional Feature:
- FREQ_GEN_BURST_EN, when defined:
  - Adds input burst_len (16) and output burst_done (1).
  - On each enable rising edge, the block emits exactly burst_len rising edges of signal_out. It then returns low after the final high phase, holds low, and pulses burst_done for one cycle.
  - burst_len==0 means continuous.
  - burst_len is sampled at the enable rising edge.
  - Dropping enable mid-burst aborts it with no burst_done.
- When undefined: neither port exists and the output is always continuous.

Test Plan:
- Reset: assert rst mid-run → next edge shows signal_out=0, half_period=0, ready=1, cfg_err=0. Release; the block stays idle.
- Load with freq_in=1000000, enable=1, idle output → ready=0 for 33 cycles. Then cfg_done=1, half_period=25, and signal_out has a 50-cycle period with 25/25 duty.
- freq_in=0 → cfg_err=1, half_period=0, cfg_done 1 cycle after the load, signal_out held low. freq_in=30000000 → half_period=1, cfg_err=1, signal_out toggles every cycle.
- Running at 1000000 Hz, load freq_in=500000 → swap at a toggle edge, half_period=50, 100-cycle period afterward, no phase shorter than 25 cycles. A second load during DIVIDE is ignored.
- Assert rst at DIVIDE cycle 10 → all outputs return to reset values, no cfg_done. A later load of 2500000 gives half_period=10.
- With FREQ_GEN_BURST_EN, half_period=25, burst_len=3 → exactly 3 rising edges, burst_done pulses once, then low. Repeat with enable dropped after the 1st edge → output low, no burst_done.
